// File: rtl/count_monitor.sv
// count_monitor: step checker for a 4-bit up/down counter with match/wrap detection and saturating event counts.
//   Parameters: WIDTH = monitored count width, EVW = event counter width.
//   Inputs:  clk, rstn (async active-low), en (monitor enable), clr (sync clear),
//            cnt_rstn / dir (counter controls as driven), cnt (counter output), target (match value).
//   Outputs: match / wrap_up / wrap_dn (one-cycle pulses), step_err (sticky),
//            match_cnt / wrap_cnt (saturating), state (0 IDLE, 1 ARMED, 2 ERROR).
module count_monitor #(
    parameter int WIDTH = 4,
    parameter int EVW   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             cnt_rstn,
    input  logic             dir,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] target,
    output logic             match,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             step_err,
    output logic [EVW-1:0]   match_cnt,
    output logic [EVW-1:0]   wrap_cnt,
    output logic [1:0]       state
);
    localparam logic [1:0]       IDLE   = 2'd0;
    localparam logic [1:0]       ARMED  = 2'd1;
    localparam logic [1:0]       ERROR  = 2'd2;
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [EVW-1:0]   EV_ONE = {{(EVW-1){1'b0}}, 1'b1};
    localparam logic [EVW-1:0]   EV_MAX = '1;

    logic [WIDTH-1:0] prev_cnt, expected;
    logic             prev_dir, prev_rstn;
    logic [1:0]       next_state;
    logic             chk, bad, legal;
    logic             match_d, wrap_up_d, wrap_dn_d, err_d;
    logic [EVW-1:0]   match_cnt_d, wrap_cnt_d;

    assign expected = !prev_rstn ? '0 : prev_dir ? prev_cnt + ONE : prev_cnt - ONE;
    assign chk      = en && state == ARMED;
    assign bad      = chk && cnt != expected;
    assign legal    = chk && cnt == expected;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clr)
            next_state = IDLE;
        else if (en)
            next_state = state == IDLE  ? ARMED :
                         state == ARMED ? (bad ? ERROR : ARMED) :
                         state == ERROR ? ERROR : IDLE;
    end

    // clr wins over any same-cycle event: pulses and counts are squashed here
    always_comb begin
        match_d     = !clr && en && state != ERROR && cnt == target;
        wrap_up_d   = !clr && legal && prev_rstn && prev_dir && prev_cnt == ONES;
        wrap_dn_d   = !clr && legal && prev_rstn && !prev_dir && prev_cnt == '0;
        err_d       = clr ? 1'b0 : (step_err || bad);
        match_cnt_d = clr ? '0 : (match_d && match_cnt != EV_MAX) ? match_cnt + EV_ONE : match_cnt;
        wrap_cnt_d  = clr ? '0 : ((wrap_up_d || wrap_dn_d) && wrap_cnt != EV_MAX) ? wrap_cnt + EV_ONE : wrap_cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match     <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
            step_err  <= 1'b0;
            match_cnt <= '0;
            wrap_cnt  <= '0;
            prev_cnt  <= '0;
            prev_dir  <= 1'b0;
            prev_rstn <= 1'b0;
        end else begin
            match     <= match_d;
            wrap_up   <= wrap_up_d;
            wrap_dn   <= wrap_dn_d;
            step_err  <= err_d;
            match_cnt <= match_cnt_d;
            wrap_cnt  <= wrap_cnt_d;
            if (en) begin
                prev_cnt  <= cnt;
                prev_dir  <= dir;
                prev_rstn <= cnt_rstn;
            end
        end
    end
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed self-checking bench for count_monitor.
module tb_count_monitor;
    logic       clk = 1'b0;
    logic       rstn, en, clr, cnt_rstn, dir;
    logic [3:0] cnt, target;
    logic       match, wrap_up, wrap_dn, step_err;
    logic [7:0] match_cnt, wrap_cnt;
    logic [1:0] state;
    int         n_cmp = 0;
    int         n_err = 0;

    count_monitor #(.WIDTH(4), .EVW(8)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .cnt_rstn(cnt_rstn), .dir(dir),
        .cnt(cnt), .target(target), .match(match), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
        .step_err(step_err), .match_cnt(match_cnt), .wrap_cnt(wrap_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic d, input logic r);
        cnt = c;
        dir = d;
        cnt_rstn = r;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; clr = 1'b0; cnt_rstn = 1'b1; dir = 1'b1;
        cnt = 4'h9; target = 4'hE;
        tick();
        chk("rst_match", 32'(match), 0);
        chk("rst_wrap_up", 32'(wrap_up), 0);
        chk("rst_wrap_dn", 32'(wrap_dn), 0);
        chk("rst_step_err", 32'(step_err), 0);
        chk("rst_match_cnt", 32'(match_cnt), 0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
        chk("rst_state", 32'(state), 0);
        cnt_rstn = 1'b0; cnt = 4'h0; rstn = 1'b1;
        tick();
        tick();
        chk("rel_state", 32'(state), 1);
        chk("rel_step_err", 32'(step_err), 0);

        for (int i = 0; i <= 32; i++) begin
            drive(4'(i), 1'b1, 1'b1);
            chk("up_match", 32'(match), 32'(i % 16 == 14));
            chk("up_wrap_up", 32'(wrap_up), 32'(i % 16 == 0 && i > 0));
        end
        chk("up_match_cnt", 32'(match_cnt), 2);
        chk("up_wrap_cnt", 32'(wrap_cnt), 2);
        chk("up_step_err", 32'(step_err), 0);

        drive(4'h1, 1'b1, 1'b1);
        drive(4'h2, 1'b1, 1'b1);
        drive(4'h3, 1'b0, 1'b1);
        drive(4'h2, 1'b0, 1'b1);
        drive(4'h1, 1'b0, 1'b1);
        drive(4'h0, 1'b0, 1'b1);
        chk("dn_no_early_wrap", 32'(wrap_dn), 0);
        drive(4'hF, 1'b0, 1'b0);
        chk("dn_wrap_dn", 32'(wrap_dn), 1);
        chk("dn_wrap_cnt", 32'(wrap_cnt), 3);
        drive(4'h0, 1'b1, 1'b1);
        chk("crst_wrap_up", 32'(wrap_up), 0);
        chk("crst_step_err", 32'(step_err), 0);
        chk("crst_state", 32'(state), 1);

        for (int v = 1; v <= 5; v++) drive(4'(v), 1'b1, 1'b1);
        chk("pre_err_step_err", 32'(step_err), 0);
        drive(4'h7, 1'b1, 1'b1);
        chk("err_step_err", 32'(step_err), 1);
        chk("err_state", 32'(state), 2);
        drive(4'hE, 1'b1, 1'b1);
        chk("err_no_match", 32'(match), 0);
        chk("err_match_cnt", 32'(match_cnt), 2);
        clr = 1'b1;
        drive(4'hE, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_state", 32'(state), 0);
        chk("clr_step_err", 32'(step_err), 0);
        chk("clr_match_cnt", 32'(match_cnt), 0);
        chk("clr_wrap_cnt", 32'(wrap_cnt), 0);

        for (int i = 0; i < 300; i++) begin
            clr = (i % 2 == 0);
            drive(4'hE, 1'b1, 1'b1);
            chk("tog_match_cnt_le1", 32'(match_cnt <= 8'd1), 1);
        end
        clr = 1'b1;
        target = 4'h0;
        drive(4'h0, 1'b1, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 300; i++) drive(4'h0, 1'b1, 1'b0);
        chk("sat_match_cnt", 32'(match_cnt), 255);
        chk("sat_step_err", 32'(step_err), 0);

        clr = 1'b1;
        target = 4'h2;
        drive(4'h0, 1'b1, 1'b1);
        clr = 1'b0;
        drive(4'h1, 1'b1, 1'b1);
        drive(4'h2, 1'b1, 1'b1);
        chk("en_match", 32'(match), 1);
        chk("en_match_cnt", 32'(match_cnt), 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'h2, 1'b1, 1'b1);
            chk("en0_match", 32'(match), 0);
            chk("en0_match_cnt", 32'(match_cnt), 1);
        end
        en = 1'b1;
        drive(4'h3, 1'b1, 1'b1);
        chk("en1_step_err", 32'(step_err), 0);
        chk("en1_state", 32'(state), 1);

        for (int v = 4; v <= 15; v++) drive(4'(v), 1'b1, 1'b1);
        clr = 1'b1;
        drive(4'h0, 1'b1, 1'b1);
        clr = 1'b0;
        chk("clrw_wrap_up", 32'(wrap_up), 0);
        chk("clrw_wrap_cnt", 32'(wrap_cnt), 0);
        chk("clrw_state", 32'(state), 0);
        drive(4'h1, 1'b1, 1'b1);
        drive(4'h2, 1'b1, 1'b1);
        chk("clrw_next_err", 32'(step_err), 0);
        chk("clrw_next_state", 32'(state), 1);
        chk("clrw_next_match", 32'(match), 1);

        #3 rstn = 1'b0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_match", 32'(match), 0);
        chk("async_match_cnt", 32'(match_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
